// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide controller that owns the HI/LO registers.
// A result is computed once when an op is accepted. It is parked in shadow registers
// and committed to HI/LO after a fixed busy latency.
module mdu_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_d,
   output logic        busy,
   output logic        stall_mdu,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // The counter is loaded with latency-1 so that busy stays high for exactly the latency.
   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_sh_q, hi_sh_d;
   logic [31:0] lo_sh_q, lo_sh_d;

   logic [63:0] mul_s;
   logic [63:0] mul_u;
   logic [31:0] divs_q, divs_r;
   logic [31:0] divu_q, divu_r;

   // Arithmetic datapath. Divide-by-zero and the signed overflow case are pinned explicitly
   // so the results never depend on how the tools treat these corner cases.
   always_comb begin
      mul_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      mul_u  = {32'd0, a} * {32'd0, b};
      divs_q = 32'hFFFF_FFFF;
      divs_r = a;
      divu_q = 32'hFFFF_FFFF;
      divu_r = a;
      if (b != 32'd0) begin
         divu_q = a / b;
         divu_r = a % b;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            divs_q = 32'h8000_0000;
            divs_r = 32'd0;
         end else begin
            divs_q = 32'($signed(a) / $signed(b));
            divs_r = 32'($signed(a) % $signed(b));
         end
      end
   end

   // Next-state logic. Ops are accepted only in IDLE, so a start during RUN changes nothing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_sh_d = hi_sh_q;
      lo_sh_d = lo_sh_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     hi_sh_d = mul_s[63:32];
                     lo_sh_d = mul_s[31:0];
                     cnt_d   = MULT_LAT;
                     state_d = RUN;
                  end
                  OP_MULTU: begin
                     hi_sh_d = mul_u[63:32];
                     lo_sh_d = mul_u[31:0];
                     cnt_d   = MULT_LAT;
                     state_d = RUN;
                  end
                  OP_DIV: begin
                     hi_sh_d = divs_r;
                     lo_sh_d = divs_q;
                     cnt_d   = DIV_LAT;
                     state_d = RUN;
                  end
                  OP_DIVU: begin
                     hi_sh_d = divu_r;
                     lo_sh_d = divu_q;
                     cnt_d   = DIV_LAT;
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == 4'd0) begin
               hi_d    = hi_sh_q;
               lo_d    = lo_sh_q;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register update. An asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_sh_q <= 32'd0;
         lo_sh_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_sh_q <= hi_sh_d;
         lo_sh_q <= lo_sh_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign stall_mdu = md_d & (start | busy);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed tests for the MDU sequencer with hand-computed expectations.
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        md_d;
   logic        busy;
   logic        stall_mdu;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int miscompares = 0;

   mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .md_d(md_d),
      .busy(busy),
      .stall_mdu(stall_mdu),
      .hi(hi),
      .lo(lo)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Last-resort guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: sim time exceeded, got hung run, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one op, then counts busy cycles. The count is capped at 20.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int cycles);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      step();
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      cycles = 0;
      while (busy && cycles < 20) begin
         cycles++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      md_d  = 1'b0;
      step();
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      vectors++;
      if (hi !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_hi: got %h expected 0", hi);
      end
      vectors++;
      if (lo !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_lo: got %h expected 0", lo);
      end
      vectors++;
      if (stall_mdu !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_stall: got %b expected 0", stall_mdu);
      end
      reset = 1'b1;
      step();
   endtask

   // Shared body for the arithmetic ops: checks the busy length and the committed HI/LO.
   task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int expCycles,
                             input logic [31:0] expHi, input logic [31:0] expLo);
      int cycles;
      run_op(o, x, y, cycles);
      vectors++;
      if (cycles !== expCycles) begin
         miscompares++;
         $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, cycles, expCycles);
      end
      vectors++;
      if (hi !== expHi) begin
         miscompares++;
         $display("[TB] FAIL %s_hi: got %h expected %h", name, hi, expHi);
      end
      vectors++;
      if (lo !== expLo) begin
         miscompares++;
         $display("[TB] FAIL %s_lo: got %h expected %h", name, lo, expLo);
      end
   endtask

   task automatic test_stall();
      int cycles;
      md_d  = 1'b1;
      start = 1'b1;
      op    = 3'd1;
      a     = 32'd1;
      b     = 32'd1;
      #1;
      vectors++;
      if (stall_mdu !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stall_accept: got %b expected 1", stall_mdu);
      end
      step();
      start = 1'b0;
      cycles = 0;
      while (stall_mdu && cycles < 20) begin
         cycles++;
         step();
      end
      vectors++;
      if (cycles !== 5) begin
         miscompares++;
         $display("[TB] FAIL stall_run_cycles: got %0d expected 5", cycles);
      end
      vectors++;
      if (stall_mdu !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL stall_release: got stall=%b busy=%b expected 0/0", stall_mdu, busy);
      end
      md_d = 1'b0;
   endtask

   task automatic test_ignore_start();
      int cycles;
      start = 1'b1;
      op    = 3'd0;
      a     = 32'd3;
      b     = 32'd4;
      step();
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 20) begin
         cycles++;
         if (cycles == 2) begin
            start = 1'b1;
            op    = 3'd2;
            a     = 32'd100;
            b     = 32'd7;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      vectors++;
      if (cycles !== 5) begin
         miscompares++;
         $display("[TB] FAIL ignore_busy_cycles: got %0d expected 5", cycles);
      end
      vectors++;
      if (hi !== 32'd0 || lo !== 32'd12) begin
         miscompares++;
         $display("[TB] FAIL ignore_result: got hi=%h lo=%h expected 0/c", hi, lo);
      end
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ignore_no_restart: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_move();
      start = 1'b1;
      op    = 3'd5;
      a     = 32'd5;
      step();
      start = 1'b0;
      vectors++;
      if (lo !== 32'd5 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mtlo: got lo=%h busy=%b expected 5/0", lo, busy);
      end
      start = 1'b1;
      op    = 3'd4;
      a     = 32'd9;
      step();
      start = 1'b0;
      vectors++;
      if (hi !== 32'd9 || lo !== 32'd5 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mthi: got hi=%h lo=%h busy=%b expected 9/5/0", hi, lo, busy);
      end
   endtask

   task automatic test_reserved();
      start = 1'b1;
      op    = 3'd6;
      a     = 32'hDEAD_BEEF;
      b     = 32'd3;
      step();
      op    = 3'd7;
      step();
      start = 1'b0;
      step();
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd9 || lo !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL reserved: got busy=%b hi=%h lo=%h expected 0/9/5", busy, hi, lo);
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      op    = 3'd2;
      a     = 32'd100;
      b     = 32'd7;
      step();
      start = 1'b0;
      step();
      step();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_immediate: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      step();
      reset = 1'b1;
      for (int i = 0; i < 15; i++) step();
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_commit: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
   endtask

   // Test sequence. Each scenario starts from the state the previous one left behind.
   initial begin
      test_reset();
      test_arith("mult",     3'd0, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      test_arith("multu",    3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
      test_arith("div",      3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_arith("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
      test_arith("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
      test_arith("divu",     3'd3, 32'hFFFF_FFF9, 32'd16, 10, 32'd9, 32'h0FFF_FFFF);
      test_stall();
      test_ignore_start();
      test_move();
      test_reserved();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
